switch_conditioner: RTL and testbench

Two-channel push-button conditioner for the BCD counter board design. Synchronises, debounces and edge-detects the raw Push and Toggle switches, then hands the BCD counter chain clean single-cycle pulses and glitch-free levels. Sits directly between the board switch pins and the counter's push/toggle inputs. An optional hold-to-repeat feature on the Push channel is compiled in by a macro.

---
 rtl/switch_conditioner_if.sv | 29 ++
 rtl/switch_conditioner.sv | 165 ++++++++++++++++
 tb/tb_switch_conditioner.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_conditioner_if.sv
// switch_conditioner_if: raw switch inputs and conditioned outputs.
// The master side (board / test harness) drives the raw pins.
// The slave side (the conditioner) drives the pulses and levels.
interface switch_conditioner_if;
  logic i_Push_Raw;
  logic i_Toggle_Raw;
  logic o_Push_Pulse;
  logic o_Push_Level;
  logic o_Toggle_Pulse;
  logic o_Toggle_Level;

  modport master (
    output i_Push_Raw,
    output i_Toggle_Raw,
    input  o_Push_Pulse,
    input  o_Push_Level,
    input  o_Toggle_Pulse,
    input  o_Toggle_Level
  );

  modport slave (
    input  i_Push_Raw,
    input  i_Toggle_Raw,
    output o_Push_Pulse,
    output o_Push_Level,
    output o_Toggle_Pulse,
    output o_Toggle_Level
  );
endinterface

// File: rtl/switch_conditioner.sv
// switch_conditioner: two-channel synchronise / debounce / press-edge detect.
// Channel 0 is Push and channel 1 is Toggle. The channels are identical and independent.
// Build macro AUTO_REPEAT_EN adds hold-to-repeat pulses on the Push channel.
//
// state         | meaning
// ST_IDLE       | released, level 0
// ST_PRESS_WAIT | counting consecutive pressed samples, level 0
// ST_PRESSED    | press accepted, level 1
// ST_REL_WAIT   | counting consecutive released samples, level still 1
module switch_conditioner #(
  parameter int DEB_CYCLES    = 1000000,
  parameter bit SW_ACTIVE_LOW = 1'b1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  switch_conditioner_if.slave  sw
);
  localparam int              CW       = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_MAX  = CW'(DEB_CYCLES);
  localparam logic            REL_LVL  = SW_ACTIVE_LOW;

  if (DEB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("switch_conditioner: illegal parameter value");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_PRESS_WAIT, ST_PRESSED, ST_REL_WAIT} state_t;

  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d, samp_q, samp_d;
  logic [1:0]    pulse_q, pulse_d, level_q, level_d;
  state_t        state_q [2];
  state_t        state_d [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_d   [2];

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPW     = $clog2(RPT_MAX + 1);
  logic [RPW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_nxt;
  logic           rpt_arm_q, rpt_arm_d;
`endif

  assign raw = {sw.i_Toggle_Raw, sw.i_Push_Raw};

  // Saturating increment keeps the stability counter from wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CW'(1);
  endfunction

  // Next-state logic: synchroniser shift, polarity normalise, per-channel debounce FSM.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    samp_d  = SW_ACTIVE_LOW ? ~sync2_q : sync2_q;
    pulse_d = 2'b00;
    level_d = level_q;
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      unique case (state_q[ch])
        ST_IDLE: begin
          if (samp_q[ch]) begin
            state_d[ch] = ST_PRESS_WAIT;
            cnt_d[ch]   = CW'(1);
          end
        end
        ST_PRESS_WAIT: begin
          if (!samp_q[ch]) begin
            state_d[ch] = ST_IDLE;
            cnt_d[ch]   = '0;
          end else if (sat_inc(cnt_q[ch]) == CNT_MAX) begin
            state_d[ch] = ST_PRESSED;
            cnt_d[ch]   = '0;
            pulse_d[ch] = 1'b1;
            level_d[ch] = 1'b1;
          end else begin
            cnt_d[ch] = sat_inc(cnt_q[ch]);
          end
        end
        ST_PRESSED: begin
          if (!samp_q[ch]) begin
            state_d[ch] = ST_REL_WAIT;
            cnt_d[ch]   = CW'(1);
          end
        end
        ST_REL_WAIT: begin
          if (samp_q[ch]) begin
            state_d[ch] = ST_PRESSED;
            cnt_d[ch]   = '0;
          end else if (sat_inc(cnt_q[ch]) == CNT_MAX) begin
            state_d[ch] = ST_IDLE;
            cnt_d[ch]   = '0;
            level_d[ch] = 1'b0;
          end else begin
            cnt_d[ch] = sat_inc(cnt_q[ch]);
          end
        end
        default: begin
          state_d[ch] = ST_IDLE;
          cnt_d[ch]   = '0;
          level_d[ch] = 1'b0;
        end
      endcase
    end

`ifdef AUTO_REPEAT_EN
    // Repeat timer advances only while held in PRESSED, freezes in REL_WAIT, clears in IDLE.
    rpt_cnt_d = rpt_cnt_q;
    rpt_arm_d = rpt_arm_q;
    rpt_nxt   = rpt_cnt_q + RPW'(1);
    if (state_q[0] == ST_PRESSED) begin
      if (rpt_nxt == (rpt_arm_q ? RPW'(REPEAT_PERIOD) : RPW'(REPEAT_DELAY))) begin
        pulse_d[0] = 1'b1;
        rpt_cnt_d  = '0;
        rpt_arm_d  = 1'b1;
      end else begin
        rpt_cnt_d = rpt_nxt;
      end
    end else if (state_q[0] == ST_IDLE) begin
      rpt_cnt_d = '0;
      rpt_arm_d = 1'b0;
    end
`endif
  end

  // State and output registers; reset parks synchronisers at the released pin level.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1_q <= {2{REL_LVL}};
      sync2_q <= {2{REL_LVL}};
      samp_q  <= 2'b00;
      pulse_q <= 2'b00;
      level_q <= 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= ST_IDLE;
        cnt_q[ch]   <= '0;
      end
`ifdef AUTO_REPEAT_EN
      rpt_cnt_q <= '0;
      rpt_arm_q <= 1'b0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      samp_q  <= samp_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
`ifdef AUTO_REPEAT_EN
      rpt_cnt_q <= rpt_cnt_d;
      rpt_arm_q <= rpt_arm_d;
`endif
    end
  end

  assign sw.o_Push_Pulse   = pulse_q[0];
  assign sw.o_Push_Level   = level_q[0];
  assign sw.o_Toggle_Pulse = pulse_q[1];
  assign sw.o_Toggle_Level = level_q[1];
endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed scenarios plus randomized switch activity,
// checked every cycle against a run-length reference model of the debounce rules.
module tb_switch_conditioner;
  localparam int D  = 8;
  localparam int RD = 40;
  localparam int RP = 10;

  logic i_Clk = 1'b0;
  logic i_Rst;
  switch_conditioner_if sw();

  switch_conditioner #(
    .DEB_CYCLES(D), .SW_ACTIVE_LOW(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .sw(sw)
  );

  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: 3-edge input latency, then a level flips once the current run of
  // identical samples reaches D and disagrees with the level.
  bit m_pipe   [2][3];
  bit m_run_val[2];
  int m_run_len[2];
  bit m_prev_s [2];
  bit m_level  [2];
  bit m_pulse  [2];
  int m_held;

  // Scenario bookkeeping from observed outputs.
  int k;
  int push_ks[$];
  int tog_ks[$];
  int p_lvl_first, p_lvl_last;
  bit t_lvl_seen;

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      for (int j = 0; j < 3; j++) m_pipe[ch][j] = 1'b0;
      m_run_val[ch] = 1'b0;
      m_run_len[ch] = 0;
      m_prev_s[ch]  = 1'b0;
      m_level[ch]   = 1'b0;
      m_pulse[ch]   = 1'b0;
    end
    m_held = 0;
  endtask

  task automatic model_edge();
    bit pressed[2];
    pressed[0] = !sw.i_Push_Raw;
    pressed[1] = !sw.i_Toggle_Raw;
    for (int ch = 0; ch < 2; ch++) begin
      bit s;
      bit in_hold;
      s = m_pipe[ch][2];
      m_pipe[ch][2] = m_pipe[ch][1];
      m_pipe[ch][1] = m_pipe[ch][0];
      m_pipe[ch][0] = pressed[ch];
      in_hold = m_level[ch] && m_prev_s[ch];
      if (s == m_run_val[ch]) m_run_len[ch]++;
      else begin
        m_run_val[ch] = s;
        m_run_len[ch] = 1;
      end
      m_prev_s[ch] = s;
      m_pulse[ch]  = 1'b0;
      if (m_run_len[ch] >= D && m_run_val[ch] != m_level[ch]) begin
        m_level[ch] = m_run_val[ch];
        m_pulse[ch] = m_level[ch];
      end
`ifdef AUTO_REPEAT_EN
      if (ch == 0) begin
        if (!m_level[0]) m_held = 0;
        else if (in_hold) begin
          m_held++;
          if (m_held == RD || (m_held > RD && (m_held - RD) % RP == 0)) m_pulse[0] = 1'b1;
        end
      end
`else
      if (in_hold) m_held = 0;
`endif
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_outputs(input string pfx);
    check_bit({pfx, ".push_pulse"},   sw.o_Push_Pulse,   m_pulse[0]);
    check_bit({pfx, ".push_level"},   sw.o_Push_Level,   m_level[0]);
    check_bit({pfx, ".toggle_pulse"}, sw.o_Toggle_Pulse, m_pulse[1]);
    check_bit({pfx, ".toggle_level"}, sw.o_Toggle_Level, m_level[1]);
  endtask

  task automatic begin_scn();
    k = 0;
    push_ks.delete();
    tog_ks.delete();
    p_lvl_first = -1;
    p_lvl_last  = -1;
    t_lvl_seen  = 1'b0;
  endtask

  // One clock: drive raw pins (pressed = 1), let the edge happen, check at the falling edge.
  task automatic tick(input bit push_pressed, input bit tog_pressed);
    sw.i_Push_Raw   = !push_pressed;
    sw.i_Toggle_Raw = !tog_pressed;
    @(posedge i_Clk);
    if (!i_Rst) model_edge();
    @(negedge i_Clk);
    cmp_outputs("cyc");
    if (sw.o_Push_Pulse === 1'b1)   push_ks.push_back(k);
    if (sw.o_Toggle_Pulse === 1'b1) tog_ks.push_back(k);
    if (sw.o_Push_Level === 1'b1) begin
      if (p_lvl_first < 0) p_lvl_first = k;
      p_lvl_last = k;
    end
    if (sw.o_Toggle_Level === 1'b1) t_lvl_seen = 1'b1;
    k++;
  endtask

  task automatic apply_reset(input bit push_pressed, input bit tog_pressed, input int cycles);
    sw.i_Push_Raw   = !push_pressed;
    sw.i_Toggle_Raw = !tog_pressed;
    i_Rst = 1'b1;
    model_reset();
    #1;
    cmp_outputs("rst");
    repeat (cycles) tick(push_pressed, tog_pressed);
    i_Rst = 1'b0;
  endtask

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  initial begin
    bit pp;
    bit tp;
    int exp_rep[$];
    i_Rst = 1'b1;
    sw.i_Push_Raw   = 1'b1;
    sw.i_Toggle_Raw = 1'b1;
    model_reset();
    @(negedge i_Clk);
    apply_reset(1'b0, 1'b0, 3);
    repeat (5) tick(1'b0, 1'b0);

    // Bounce on Toggle: runs of 5 never qualify.
    begin_scn();
    repeat (5)  tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    repeat (5)  tick(1'b0, 1'b1);
    repeat (15) tick(1'b0, 1'b0);
    check_int("bounce.pulses", tog_ks.size(), 0);
    check_int("bounce.level_seen", int'(t_lvl_seen), 0);

    // Clean Push press, pulse and level one cycle after edge 10.
    begin_scn();
    repeat (30) tick(1'b1, 1'b0);
    check_int("press.pulses", push_ks.size(), 1);
    check_int("press.pulse_k", first_of(push_ks), 10);
    check_int("press.level_k", p_lvl_first, 10);

    // Release with a 3-cycle re-press glitch at release+4.
    begin_scn();
    repeat (4)  tick(1'b0, 1'b0);
    repeat (3)  tick(1'b1, 1'b0);
    repeat (20) tick(1'b0, 1'b0);
    check_int("release.pulses", push_ks.size(), 0);
    check_int("release.last_level_k", p_lvl_last, 16);

    // Simultaneous press on both channels.
    begin_scn();
    repeat (20) tick(1'b1, 1'b1);
    check_int("simul.push_pulses", push_ks.size(), 1);
    check_int("simul.tog_pulses", tog_ks.size(), 1);
    check_int("simul.push_k", first_of(push_ks), 10);
    check_int("simul.tog_k", first_of(tog_ks), 10);
    repeat (20) tick(1'b0, 1'b0);

    // Reset while Push is held; must re-qualify and pulse once.
    begin_scn();
    repeat (12) tick(1'b1, 1'b0);
    apply_reset(1'b1, 1'b0, 3);
    begin_scn();
    repeat (20) tick(1'b1, 1'b0);
    check_int("rsthold.pulses", push_ks.size(), 1);
    check_int("rsthold.pulse_k", first_of(push_ks), 10);
    repeat (20) tick(1'b0, 1'b0);

    // Long hold: repeat pulses when the feature is built in, single pulse otherwise.
    begin_scn();
    repeat (80) tick(1'b1, 1'b0);
    repeat (30) tick(1'b0, 1'b0);
`ifdef AUTO_REPEAT_EN
    exp_rep = '{10, 50, 60, 70, 80};
`else
    exp_rep = '{10};
`endif
    check_int("hold.pulses", push_ks.size(), exp_rep.size());
    foreach (exp_rep[i]) check_int("hold.pulse_k", (i < push_ks.size()) ? push_ks[i] : -1, exp_rep[i]);

    // Randomized activity: short bouncy runs, then long holds, rare resets.
    pp = 1'b0;
    tp = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 8) == 0) pp = !pp;
      if ($urandom_range(0, 8) == 0) tp = !tp;
      if ($urandom_range(0, 299) == 0) apply_reset(pp, tp, 2);
      else tick(pp, tp);
    end
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) pp = !pp;
      if ($urandom_range(0, 29) == 0) tp = !tp;
      tick(pp, tp);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
